// File: rtl/verdict_capture_fifo.sv
// Timestamps active monitor verdicts and buffers {ts, verdict} pairs for a valid/ready drain.
// Define VERDICT_DEDUP_EN to suppress pushes that repeat the last accepted verdict.
module verdict_capture_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TS_W   = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [DATA_W-1:0]      verdict,
    input  logic                   verdict_aktv,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W-1:0]      m_data,
    output logic [TS_W-1:0]        m_ts,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       drop_cnt,
    output logic                   overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]     PTR_ONE = 1;
    localparam logic [TS_W-1:0] TS_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TS_W-1:0]   ts_mem   [DEPTH];

    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [TS_W-1:0]   ts_q;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic              overflow_q;

    logic empty, full, pop, push, drop, attempt;

    assign empty = (wr_ptr_q == rd_ptr_q);
    // Full: same slot index, opposite wrap bit.
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop   = !empty && m_ready;
    assign push  = attempt && (!full || pop);
    assign drop  = attempt && full && !pop;

`ifdef VERDICT_DEDUP_EN
    logic [DATA_W-1:0] last_q;
    logic              last_valid_q;

    assign attempt = en && verdict_aktv && !(last_valid_q && (verdict == last_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else if (push) begin
            last_q       <= verdict;
            last_valid_q <= 1'b1;
        end
    end
`else
    assign attempt = en && verdict_aktv;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ts_q       <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (en) begin
                ts_q <= ts_q + TS_ONE;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + CNT_ONE;
                end
            end
        end
    end

    // Storage needs no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            data_mem[wr_ptr_q[AW-1:0]] <= verdict;
            ts_mem[wr_ptr_q[AW-1:0]]   <= ts_q;
        end
    end

    always_comb begin
        m_valid = !empty;
        m_data  = '0;
        m_ts    = '0;
        if (!empty) begin
            m_data = data_mem[rd_ptr_q[AW-1:0]];
            m_ts   = ts_mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign level    = wr_ptr_q - rd_ptr_q;
    assign drop_cnt = drop_cnt_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_verdict_capture_fifo.sv
// Bench for verdict_capture_fifo: a default instance plus a narrow one (TS_W=8, CNT_W=4)
// driven identically, both checked against a queue-based reference model.
module tb_verdict_capture_fifo;
    localparam int DEPTH = 16;
    localparam logic [63:0] NEG7 = -64'sd7;

    logic        clk;
    logic        rst, en, aktv, ready;
    logic [63:0] verdict;

    logic        a_valid, b_valid;
    logic [63:0] a_data, b_data;
    logic [31:0] a_ts;
    logic [7:0]  b_ts;
    logic [4:0]  a_level, b_level;
    logic [15:0] a_drop;
    logic [3:0]  b_drop;
    logic        a_ovf, b_ovf;

    verdict_capture_fifo #(
        .DATA_W (64),
        .TS_W   (32),
        .DEPTH  (DEPTH),
        .CNT_W  (16)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .verdict      (verdict),
        .verdict_aktv (aktv),
        .m_valid      (a_valid),
        .m_ready      (ready),
        .m_data       (a_data),
        .m_ts         (a_ts),
        .level        (a_level),
        .drop_cnt     (a_drop),
        .overflow     (a_ovf)
    );

    verdict_capture_fifo #(
        .DATA_W (64),
        .TS_W   (8),
        .DEPTH  (DEPTH),
        .CNT_W  (4)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .verdict      (verdict),
        .verdict_aktv (aktv),
        .m_valid      (b_valid),
        .m_ready      (ready),
        .m_data       (b_data),
        .m_ts         (b_ts),
        .level        (b_level),
        .drop_cnt     (b_drop),
        .overflow     (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ts;
        logic [63:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mts;
    int          mdrop;
    bit          movf;
    logic [63:0] mlast;
    bit          mlast_v;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic        ev;
        logic [63:0] ed;
        logic [31:0] et;
        ev = (q.size() != 0);
        ed = ev ? q[0].data : 64'd0;
        et = ev ? q[0].ts : 32'd0;
        chk("a_valid", 64'(a_valid), 64'(ev));
        chk("a_data", a_data, ed);
        chk("a_ts", 64'(a_ts), 64'(et));
        chk("a_level", 64'(a_level), 64'(q.size()));
        chk("a_drop", 64'(a_drop), 64'((mdrop > 65535) ? 65535 : mdrop));
        chk("a_ovf", 64'(a_ovf), 64'(movf));
        chk("b_valid", 64'(b_valid), 64'(ev));
        chk("b_data", b_data, ed);
        chk("b_ts", 64'(b_ts), 64'(et[7:0]));
        chk("b_level", 64'(b_level), 64'(q.size()));
        chk("b_drop", 64'(b_drop), 64'((mdrop > 15) ? 15 : mdrop));
        chk("b_ovf", 64'(b_ovf), 64'(movf));
    endtask

    // Apply one cycle of inputs, advance the model, then check both instances.
    task automatic step(input logic r, input logic e, input logic a, input logic [63:0] v,
                        input logic rd);
        bit pop, att, was_full;
        rst = r; en = e; aktv = a; verdict = v; ready = rd;
        if (r) begin
            q.delete();
            mts = 0; mdrop = 0; movf = 0; mlast = 0; mlast_v = 0;
        end else begin
            was_full = (q.size() == DEPTH);
            pop = rd && (q.size() != 0);
            att = e && a;
`ifdef VERDICT_DEDUP_EN
            if (mlast_v && v == mlast) att = 0;
`endif
            if (pop) void'(q.pop_front());
            if (att) begin
                if (!was_full || pop) begin
                    q.push_back('{ts: mts, data: v});
                    mlast = v;
                    mlast_v = 1;
                end else begin
                    mdrop++;
                    movf = 1;
                end
            end
            if (e) mts = mts + 32'd1;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        aktv;
        logic [63:0] verdict;
        logic        ready;
        int          exp_level;
        int          exp_drop;
        logic [63:0] exp_head;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic [31:0] t0;
        logic [63:0] v;
        rst = 1; en = 0; aktv = 0; ready = 0; verdict = '0;

        // Fill plus full-FIFO push-with-pop vectors.
        for (int i = 0; i < 19; i++) begin
            tbl[i] = '{aktv: 1'b1, verdict: 64'(i + 1), ready: 1'b0,
                       exp_level: (i < 16) ? i + 1 : 16, exp_drop: (i < 16) ? 0 : i - 15,
                       exp_head: 64'd1};
        end
        tbl[19] = '{aktv: 1'b1, verdict: NEG7, ready: 1'b1, exp_level: 16, exp_drop: 3,
                    exp_head: 64'd2};

        // Reset and first capture at ts=500.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_valid", 64'(a_valid), 64'd0);
        chk("rst_level", 64'(a_level), 64'd0);
        for (int i = 0; i < 500; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 64'd1, 0);
        chk("t1_ts", 64'(a_ts), 64'd500);
        chk("t1_data", a_data, 64'd1);
        chk("t1_level", 64'(a_level), 64'd1);
        step(0, 1, 0, 0, 1);
        chk("t1_empty", 64'(a_valid), 64'd0);

        // Overflow then simultaneous pop+push while full.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, tbl[i].aktv, tbl[i].verdict, tbl[i].ready);
            chk("tbl_level", 64'(a_level), 64'(tbl[i].exp_level));
            chk("tbl_drop", 64'(a_drop), 64'(tbl[i].exp_drop));
            chk("tbl_head", a_data, tbl[i].exp_head);
        end
        chk("t2_ovf", 64'(a_ovf), 64'd1);
        t0 = a_ts;
        for (int i = 0; i < 16; i++) begin
            v = (i < 15) ? 64'(i + 2) : NEG7;
            chk("drain_data", a_data, v);
            if (i < 15) chk("drain_ts", 64'(a_ts), 64'(t0 + 32'(i)));
            step(0, 1, 0, 0, 1);
        end
        chk("drain_empty", 64'(a_level), 64'd0);

        // Drop counter saturation on the narrow instance.
        for (int i = 0; i < 30; i++) step(0, 1, 1, 64'(100 + i), 0);
        chk("sat_b", 64'(b_drop), 64'd15);
        chk("sat_a", 64'(a_drop), 64'd17);

        // Reset with 3 entries and overflow, colliding with pop and push.
        for (int i = 0; i < 13; i++) step(0, 1, 0, 0, 1);
        chk("t5_level", 64'(a_level), 64'd3);
        step(1, 1, 1, 64'd9, 1);
        chk("t5_valid", 64'(a_valid), 64'd0);
        chk("t5_level0", 64'(a_level), 64'd0);
        chk("t5_drop", 64'(a_drop), 64'd0);
        chk("t5_ovf", 64'(a_ovf), 64'd0);
        chk("t5_data", a_data, 64'd0);

        // Timestamp wrap on the 8-bit instance and freeze with en=0.
        for (int i = 0; i < 256; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 64'd42, 0);
        chk("wrap_b_ts", 64'(b_ts), 64'd0);
        chk("wrap_a_ts", 64'(a_ts), 64'd256);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 64'(43 + i), 0);
        chk("freeze_level", 64'(a_level), 64'd1);
        step(0, 1, 1, 64'd77, 0);
        step(0, 1, 0, 0, 1);
        chk("freeze_ts_b", 64'(b_ts), 64'd1);
        chk("freeze_data", a_data, 64'd77);

        // Dedup of repeated verdicts.
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 64'd5, 0);
        step(0, 1, 1, 64'd5, 0);
        step(0, 1, 1, 64'd6, 0);
`ifdef VERDICT_DEDUP_EN
        chk("dedup_level", 64'(a_level), 64'd2);
`else
        chk("dedup_level", 64'(a_level), 64'd3);
`endif
        chk("dedup_drop", 64'(a_drop), 64'd0);

        // Randomized traffic with varying drain pressure.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 500; i++) begin
                v = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                 : 64'($urandom_range(0, 2));
                step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                     ($urandom_range(0, 2) != 0), v,
                     ($urandom_range(0, 3) < ph));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/verdict_capture_fifo.md
Name: verdict_capture_fifo

Overview:
- Downstream of the generated monitor top entity.
- Captures every active verdict (output_0 while output_0_aktv is high) and tags it with a free-running cycle timestamp.
- Buffers {timestamp, verdict} pairs in a FIFO and drains them over a valid/ready stream to a logger/host interface.
- Counts verdicts lost to overflow, so bursts of outputs are never silently lost.

Parameters:
- DATA_W, 64, verdict width (signed), matches monitor output stream width.
- TS_W, 32, timestamp counter width.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CNT_W, 16, drop counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  global enable (same signal as the monitor's en).
- verdict  in  DATA_W  signed verdict from monitor output_0.
- verdict_aktv  in  1  monitor output_0_aktv; verdict valid this cycle.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accepts head.
- m_data  out  DATA_W  head verdict.
- m_ts  out  TS_W  head timestamp.
- level  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  CNT_W  verdicts dropped on full; saturating.
- overflow  out  1  sticky, set on first drop.

Behaviour:
- Reset: rst is synchronous; at a clk edge with rst=1:
  - ts counter, read/write pointers, drop_cnt and overflow are cleared to 0.
  - Next cycle: m_valid=0, m_data=0, m_ts=0, level=0.
  - rst has priority over every push and pop in the same cycle. Mid-operation reset discards all stored entries.
- Timestamp:
  - ts increments by 1 at each edge with en=1; holds when en=0.
  - Wraps modulo 2^TS_W.
  - The captured timestamp is the ts value before that edge's increment.
- Push:
  - At an edge with en=1 and verdict_aktv=1, the pair {ts, verdict} is written if the FIFO is not full, or if it is full and a pop occurs at the same edge.
  - en=0 blocks capture regardless of verdict_aktv.
- Drop:
  - A push attempt while full with no simultaneous pop discards the entry.
  - drop_cnt +1, saturating at 2^CNT_W-1; overflow set to 1.
  - overflow is cleared only by rst.
- Pop:
  - Occurs at an edge with m_valid=1 and m_ready=1. Independent of en; the drain side keeps running while the monitor is disabled.
  - m_ready while empty has no effect.
- Output timing:
  - First-word fall-through; m_valid = (level != 0).
  - An entry pushed at edge N is visible on m_data/m_ts after edge N (1-cycle latency, empty to valid).
  - m_data/m_ts are driven 0 whenever m_valid=0.
  - m_data/m_ts are stable while m_valid=1 and m_ready=0.
- Simultaneous push and pop:
  - Non-empty FIFO: both take effect, level unchanged.
  - Empty FIFO: only the push takes effect (no pop possible).
- Ordering: strict FIFO. Pointers carry one extra wrap bit; full = same index with differing wrap bit; empty = pointers equal.
- Arithmetic: verdict is stored verbatim, no sign extension or truncation. Counters are unsigned.

Optional Feature:
- Macro: VERDICT_DEDUP_EN.
- When defined:
  - Holds a last-accepted verdict register plus a last_valid flag; both cleared by rst.
  - A push attempt whose verdict equals the last accepted verdict (with last_valid=1) is suppressed: no write, no drop count, ts still advances.
  - The last-accepted register updates only on accepted pushes, not on drops.
- When undefined: every active verdict is a push attempt; no extra registers.

Test Plan:
1. Reset 2 cycles, then idle with en=1 until ts=500; pulse verdict_aktv with verdict=1 -> next cycle m_valid=1, m_data=1, m_ts=500, level=1; m_ready=1 one cycle -> m_valid=0, level=0.
2. DEPTH=16, m_ready=0, verdict_aktv high 19 consecutive cycles with values 1..19 -> level=16, drop_cnt=3, overflow=1; then drain -> m_data sequence 1..16 with consecutive m_ts.
3. FIFO full, m_ready=1 plus verdict_aktv with verdict=-7 at the same edge -> pop and push both accepted, level stays 16, drop_cnt unchanged, -7 appears last on drain.
4. TS_W=8: capture at the 257th enabled cycle after reset (ts wrapped) -> m_ts=0x00; then en=0 for 10 cycles with verdict_aktv=1 -> no pushes, ts frozen.
5. Three entries stored, overflow=1, assert rst one cycle together with m_ready=1 and verdict_aktv=1 -> following cycle m_valid=0, level=0, drop_cnt=0, overflow=0, m_data=0.
6. Verdicts 5,5,6 on consecutive active cycles -> with VERDICT_DEDUP_EN level=2 (5,6); without level=3 (5,5,6); drop_cnt=0 in both builds.
